// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU round-robin arbiter.
package alu_arb_pkg;

    localparam int unsigned RES_W  = 16;
    localparam int unsigned OPND_W = 8;
    localparam int unsigned OP_W   = 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CAPT,
        RESP
    } state_t;

    // (base + off) mod n, valid for base < n and off <= n.
    function automatic logic [31:0] wrap_add(logic [31:0] base, logic [31:0] off,
                                             logic [31:0] n);
        logic [31:0] s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/alu_rr_picker.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
module alu_rr_picker
    import alu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    logic [31:0]     cand;
    logic [ID_W-1:0] cand_idx;

    // Scan from the pointer upwards; the first hit wins and later hits are ignored.
    always_comb begin
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = '0;
        cand_idx = '0;
        for (int off = 0; off < int'(NUM_REQ); off++) begin
            cand     = wrap_add(32'(ptr), 32'(off), 32'(NUM_REQ));
            cand_idx = ID_W'(cand);
            if (!any && valid[cand_idx]) begin
                any             = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one registered 8-bit ALU between NUM_REQ requesters.
// One op in flight at a time: IDLE (grant/accept) -> EXEC -> CAPT -> RESP.
// Optional build macro ALU_ARB_STATS_EN adds per-requester 16-bit grant counters
// on output stat_grant_cnt.
module alu_rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      CLk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OPND_W-1:0] req_a,
    input  logic [NUM_REQ*OPND_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ-1:0]        req_cin,
    output logic [OPND_W-1:0]         alu_a,
    output logic [OPND_W-1:0]         alu_b,
    output logic [OP_W-1:0]           alu_op,
    output logic                      alu_cin,
    input  logic [RES_W-1:0]          alu_result,
    input  logic                      alu_cout,
    input  logic                      alu_zflag,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [RES_W-1:0]          rsp_result,
    output logic                      rsp_cout,
    output logic                      rsp_zflag
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     stat_grant_cnt
`endif
);

    state_t              state_q;
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     id_q;
    logic [OPND_W-1:0]   a_q;
    logic [OPND_W-1:0]   b_q;
    logic [OP_W-1:0]     op_q;
    logic                cin_q;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;
    logic                accept;

    logic [OPND_W-1:0]   sel_a;
    logic [OPND_W-1:0]   sel_b;
    logic [OP_W-1:0]     sel_op;
    logic                sel_cin;

    alu_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // Ready is offered only while idle; held low during reset so outputs read 0.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && !Reset && grant_any) begin
            req_ready = grant;
        end
    end

    assign accept = |(req_valid & req_ready);

    // Operand mux for the granted requester.
    always_comb begin
        sel_a   = req_a[grant_idx*OPND_W +: OPND_W];
        sel_b   = req_b[grant_idx*OPND_W +: OPND_W];
        sel_op  = req_op[grant_idx*OP_W +: OP_W];
        sel_cin = req_cin[grant_idx];
    end

    // ALU inputs come straight from the latched op, so they hold between ops.
    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_op  = op_q;
    assign alu_cin = cin_q;

    // Main FSM with registered response outputs.
    always_ff @(posedge CLk) begin
        if (Reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            cin_q      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_zflag  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        op_q    <= sel_op;
                        cin_q   <= sel_cin;
                        id_q    <= grant_idx;
                        ptr_q   <= ID_W'(wrap_add(32'(grant_idx), 32'd1, 32'(NUM_REQ)));
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU samples the held operands at the end of this cycle.
                    state_q <= CAPT;
                end
                CAPT: begin
                    rsp_result <= alu_result;
                    rsp_zflag  <= alu_zflag;
                    // Carry is only meaningful for addition.
                    rsp_cout   <= (op_q == OP_ADD) ? alu_cout : 1'b0;
                    rsp_id     <= id_q;
                    rsp_valid  <= 1'b1;
                    state_q    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] grant_cnt_q;

    // Per-requester wrapping count of accepted ops.
    always_ff @(posedge CLk) begin
        if (Reset) begin
            grant_cnt_q <= '0;
        end else if (state_q == IDLE && accept) begin
            grant_cnt_q[grant_idx] <= grant_cnt_q[grant_idx] + 16'd1;
        end
    end

    assign stat_grant_cnt = grant_cnt_q;
`endif

endmodule
